// File: rtl/track_pooler_if.sv
// Handshake and result bus between the drawing stage (master) and the track pooler (slave).
interface track_pooler_if #(
    parameter int SIDE = 52,
    parameter int POOL = 4
);
    localparam int OUT = SIDE / POOL;

    logic                   start;
    logic [SIDE*SIDE-1:0]   track;
    logic                   busy;
    logic                   done;
    logic [OUT*OUT-1:0]     pooled;
    logic [11:0]            ink_count;
    logic                   empty;
    logic [23:0]            bbox;

    modport master (
        output start, track,
        input  busy, done, pooled, ink_count, empty, bbox
    );

    modport slave (
        input  start, track,
        output busy, done, pooled, ink_count, empty, bbox
    );
endinterface

// File: rtl/track_pooler.sv
// Snapshots a SIDE x SIDE track bitmap and pools it serially, one POOL x POOL cell per clock.
// Bounding-box tracking is built only when TRACK_POOLER_BBOX_EN is defined; otherwise bbox is 0.
module track_pooler #(
    parameter int SIDE   = 52,
    parameter int POOL   = 4,
    parameter int THRESH = 1
) (
    input  logic          clk,
    input  logic          rst,
    track_pooler_if.slave bus
);
    localparam int OUT   = SIDE / POOL;
    localparam int CELLS = OUT * OUT;
    localparam int NPIX  = SIDE * SIDE;
    localparam int KW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int OW    = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int PW    = $clog2(NPIX);
    localparam int NW    = $clog2(POOL * POOL + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e           state, state_nxt;
    logic             capture, scan_en, publish;

    logic [NPIX-1:0]  snap;
    logic [KW-1:0]    k_q;
    logic [OW-1:0]    row_q, col_q;
    logic [CELLS-1:0] pool_w;
    logic [11:0]      ink_w;
    logic [PW-1:0]    pix_idx;
    logic [NW-1:0]    win_n;

    logic             busy_q, done_q, empty_q;
    logic [CELLS-1:0] pooled_q;
    logic [11:0]      ink_q;
    logic [23:0]      bbox_q;

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && !done_q) state_nxt = SCAN;
            SCAN:    if (k_q == KW'(CELLS - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A start coinciding with the done pulse is dropped even though the FSM is already IDLE.
    always_comb begin
        capture = (state == IDLE) && bus.start && !done_q;
        scan_en = (state == SCAN);
        publish = (state == DONE);
    end

    // NOTE: the snapshot is always written before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) snap <= bus.track;
    end

`ifdef TRACK_POOLER_BBOX_EN
    logic [5:0] win_min_x, win_max_x, win_min_y, win_max_y;
    logic [5:0] bb_min_x, bb_max_x, bb_min_y, bb_max_y;
    logic       win_any, bb_any;
`endif

    always_comb begin
        pix_idx = '0;
        win_n   = '0;
`ifdef TRACK_POOLER_BBOX_EN
        win_any   = 1'b0;
        win_min_x = '1;
        win_max_x = '0;
        win_min_y = '1;
        win_max_y = '0;
`endif
        for (int dy = 0; dy < POOL; dy++) begin
            for (int dx = 0; dx < POOL; dx++) begin
                pix_idx = PW'((int'(row_q) * POOL + dy) * SIDE + int'(col_q) * POOL + dx);
                win_n   = win_n + NW'(snap[pix_idx]);
`ifdef TRACK_POOLER_BBOX_EN
                if (snap[pix_idx]) begin
                    win_any = 1'b1;
                    if (6'(int'(col_q) * POOL + dx) < win_min_x) win_min_x = 6'(int'(col_q) * POOL + dx);
                    if (6'(int'(col_q) * POOL + dx) > win_max_x) win_max_x = 6'(int'(col_q) * POOL + dx);
                    if (6'(int'(row_q) * POOL + dy) < win_min_y) win_min_y = 6'(int'(row_q) * POOL + dy);
                    if (6'(int'(row_q) * POOL + dy) > win_max_y) win_max_y = 6'(int'(row_q) * POOL + dy);
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            pool_w   <= '0;
            ink_w    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            empty_q  <= 1'b1;
            pooled_q <= '0;
            ink_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (capture) begin
                k_q    <= '0;
                row_q  <= '0;
                col_q  <= '0;
                pool_w <= '0;
                ink_w  <= '0;
                busy_q <= 1'b1;
            end
            if (scan_en) begin
                pool_w[k_q] <= (win_n >= NW'(THRESH));
                ink_w       <= ink_w + 12'(win_n);
                k_q         <= k_q + KW'(1);
                if (col_q == OW'(OUT - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + OW'(1);
                end else begin
                    col_q <= col_q + OW'(1);
                end
            end
            if (publish) begin
                pooled_q <= pool_w;
                ink_q    <= ink_w;
                empty_q  <= (ink_w == 12'd0);
                done_q   <= 1'b1;
                busy_q   <= 1'b0;
            end
        end
    end

`ifdef TRACK_POOLER_BBOX_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            bb_any   <= 1'b0;
            bb_min_x <= '0;
            bb_max_x <= '0;
            bb_min_y <= '0;
            bb_max_y <= '0;
            bbox_q   <= '0;
        end else begin
            if (capture) bb_any <= 1'b0;
            if (scan_en && win_any) begin
                bb_any   <= 1'b1;
                bb_min_x <= (!bb_any || win_min_x < bb_min_x) ? win_min_x : bb_min_x;
                bb_max_x <= (!bb_any || win_max_x > bb_max_x) ? win_max_x : bb_max_x;
                bb_min_y <= (!bb_any || win_min_y < bb_min_y) ? win_min_y : bb_min_y;
                bb_max_y <= (!bb_any || win_max_y > bb_max_y) ? win_max_y : bb_max_y;
            end
            if (publish) bbox_q <= bb_any ? {bb_max_y, bb_max_x, bb_min_y, bb_min_x} : 24'd0;
        end
    end
`else
    assign bbox_q = '0;
`endif

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pooled    = pooled_q;
    assign bus.ink_count = ink_q;
    assign bus.empty     = empty_q;
    assign bus.bbox      = bbox_q;
endmodule

// File: tb/tb_track_pooler.sv
// Randomised and directed bench for track_pooler: two instances (THRESH=1 and THRESH=2) share stimulus
// and are compared against a whole-image reference model.
module tb_track_pooler;
    localparam int SIDE  = 52;
    localparam int POOL  = 4;
    localparam int OUT   = SIDE / POOL;
    localparam int CELLS = OUT * OUT;
    localparam int NPIX  = SIDE * SIDE;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start_r = 1'b0;
    logic [NPIX-1:0]  track_r = '0;

    int               vectors = 0;
    int               miscompares = 0;

    logic [CELLS-1:0] exp_p1, exp_p2;
    int               exp_ink;
    logic [23:0]      exp_bb;
    logic [NPIX-1:0]  t_a, t_b;

    always #5 clk = ~clk;

    track_pooler_if #(.SIDE(SIDE), .POOL(POOL)) bus1();
    track_pooler_if #(.SIDE(SIDE), .POOL(POOL)) bus2();

    assign bus1.start = start_r;
    assign bus1.track = track_r;
    assign bus2.start = start_r;
    assign bus2.track = track_r;

    track_pooler #(.SIDE(SIDE), .POOL(POOL), .THRESH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    track_pooler #(.SIDE(SIDE), .POOL(POOL), .THRESH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: count every set pixel into its pooled cell, then threshold each cell.
    task automatic model(input logic [NPIX-1:0] t, input int thresh,
                         output logic [CELLS-1:0] p, output int ink);
        int cnt [CELLS];
        for (int i = 0; i < CELLS; i++) cnt[i] = 0;
        ink = 0;
        p   = '0;
        for (int y = 0; y < SIDE; y++)
            for (int x = 0; x < SIDE; x++)
                if (t[y*SIDE + x]) begin
                    cnt[(y / POOL) * OUT + x / POOL]++;
                    ink++;
                end
        for (int i = 0; i < CELLS; i++) p[i] = (cnt[i] >= thresh);
    endtask

    function automatic logic [23:0] bbox_model(input logic [NPIX-1:0] t);
        int mnx = SIDE, mny = SIDE, mxx = -1, mxy = -1;
        for (int y = 0; y < SIDE; y++)
            for (int x = 0; x < SIDE; x++)
                if (t[y*SIDE + x]) begin
                    if (x < mnx) mnx = x;
                    if (x > mxx) mxx = x;
                    if (y < mny) mny = y;
                    if (y > mxy) mxy = y;
                end
`ifdef TRACK_POOLER_BBOX_EN
        if (mxx < 0) return 24'd0;
        return {6'(mxy), 6'(mxx), 6'(mny), 6'(mnx)};
`else
        return 24'd0;
`endif
    endfunction

    task automatic predict(input logic [NPIX-1:0] t);
        int ink2;
        model(t, 1, exp_p1, exp_ink);
        model(t, 2, exp_p2, ink2);
        exp_bb = bbox_model(t);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".pooled_t1"}, 256'(bus1.pooled), 256'(exp_p1));
        check({tag, ".pooled_t2"}, 256'(bus2.pooled), 256'(exp_p2));
        check({tag, ".ink_t1"},    256'(bus1.ink_count), 256'(exp_ink));
        check({tag, ".ink_t2"},    256'(bus2.ink_count), 256'(exp_ink));
        check({tag, ".empty_t1"},  256'(bus1.empty), 256'(exp_ink == 0));
        check({tag, ".empty_t2"},  256'(bus2.empty), 256'(exp_ink == 0));
        check({tag, ".bbox"},      256'(bus1.bbox), 256'(exp_bb));
    endtask

    // Runs one scan of t. inject_at >= 0 re-strobes start with a different track mid-scan.
    task automatic scan(input string tag, input logic [NPIX-1:0] t, input int inject_at,
                        input bit restart_on_done);
        int edges, busy_cycles, extra_done;
        bit seen;
        predict(t);
        @(negedge clk);
        track_r = t;
        start_r = 1'b1;
        @(posedge clk);
        #1 start_r = 1'b0;
        busy_cycles = bus1.busy ? 1 : 0;
        edges = 0;
        seen  = 1'b0;
        while (edges < 400) begin
            if (edges == inject_at) begin
                track_r = ~t;
                start_r = 1'b1;
            end
            @(posedge clk);
            #1 start_r = 1'b0;
            edges++;
            if (bus1.done) begin
                seen = 1'b1;
                break;
            end
            if (bus1.busy) busy_cycles++;
        end
        check({tag, ".done_seen"}, 256'(seen), 256'(1));
        check({tag, ".latency"},   256'(edges), 256'(170));
        check({tag, ".busy_len"},  256'(busy_cycles), 256'(170));
        check({tag, ".done_t2"},   256'(bus2.done), 256'(1));
        check({tag, ".busy_end"},  256'(bus1.busy), 256'(0));
        check_outputs(tag);
        if (restart_on_done) start_r = 1'b1;
        @(posedge clk);
        #1 start_r = 1'b0;
        check({tag, ".done_pulse"}, 256'(bus1.done), 256'(0));
        check({tag, ".no_restart"}, 256'(bus1.busy), 256'(0));
        if (inject_at >= 0) begin
            extra_done = 0;
            repeat (200) begin
                @(posedge clk);
                #1 if (bus1.done || bus1.busy) extra_done++;
            end
            check({tag, ".no_requeue"}, 256'(extra_done), 256'(0));
            check_outputs({tag, ".held"});
        end
    endtask

    initial begin
        int dens, extra_done;

        repeat (3) @(posedge clk);
        #1;
        check("reset.busy",   256'(bus1.busy), 256'(0));
        check("reset.done",   256'(bus1.done), 256'(0));
        check("reset.pooled", 256'(bus1.pooled), 256'(0));
        check("reset.ink",    256'(bus1.ink_count), 256'(0));
        check("reset.empty",  256'(bus1.empty), 256'(1));
        check("reset.bbox",   256'(bus1.bbox), 256'(0));
        @(negedge clk) rst = 1'b1;

        scan("zero", '0, -1, 1'b1);

        t_a = '0;
        t_a[0] = 1'b1;
        scan("px00", t_a, -1, 1'b0);
        check("px00.bit0_only", 256'(bus1.pooled), 256'(1));

        t_a = '0;
        t_a[51*SIDE + 51] = 1'b1;
        scan("px5151", t_a, -1, 1'b0);
        check("px5151.bit168", 256'(bus1.pooled[168]), 256'(1));

        t_a = '0;
        for (int y = 8; y < 12; y++)
            for (int x = 4; x < 8; x++) t_a[y*SIDE + x] = 1'b1;
        t_a[20*SIDE + 20] = 1'b1;
        scan("block", t_a, -1, 1'b0);
        check("block.t2_bit27", 256'(bus2.pooled[27]), 256'(1));
        check("block.t2_bit70", 256'(bus2.pooled[70]), 256'(0));
        check("block.ink17",    256'(bus2.ink_count), 256'(17));

        scan("ones", '1, -1, 1'b0);
        check("ones.ink2704", 256'(bus1.ink_count), 256'(2704));

        for (int i = 0; i < NPIX; i++) t_a[i] = ($urandom_range(0, 99) < 20);
        scan("inject", t_a, 50, 1'b0);

        // Reset during a scan that follows a completed one.
        for (int i = 0; i < NPIX; i++) t_a[i] = ($urandom_range(0, 99) < 5);
        for (int i = 0; i < NPIX; i++) t_b[i] = ($urandom_range(0, 99) < 40);
        scan("rst_prev", t_a, -1, 1'b0);
        @(negedge clk);
        track_r = t_b;
        start_r = 1'b1;
        @(posedge clk);
        #1 start_r = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("rst.busy_mid", 256'(bus1.busy), 256'(1));
        check_outputs("rst.hold");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst.busy",    256'(bus1.busy), 256'(0));
        check("rst.done",    256'(bus1.done), 256'(0));
        check("rst.pooled1", 256'(bus1.pooled), 256'(0));
        check("rst.pooled2", 256'(bus2.pooled), 256'(0));
        check("rst.ink",     256'(bus1.ink_count), 256'(0));
        check("rst.empty",   256'(bus1.empty), 256'(1));
        check("rst.bbox",    256'(bus1.bbox), 256'(0));
        @(negedge clk) rst = 1'b1;
        extra_done = 0;
        repeat (200) begin
            @(posedge clk);
            #1 if (bus1.done || bus2.done) extra_done++;
        end
        check("rst.no_done", 256'(extra_done), 256'(0));
        scan("after_rst", t_b, -1, 1'b0);

        for (int n = 0; n < 6; n++) begin
            case (n % 4)
                0: dens = 1;
                1: dens = 4;
                2: dens = 15;
                default: dens = 60;
            endcase
            for (int i = 0; i < NPIX; i++) t_a[i] = ($urandom_range(0, 99) < dens);
            scan($sformatf("rand%0d", n), t_a, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/track_pooler.md
Name: track_pooler

Overview:
- Sits between the mouse-drawing stage and the digit predictor.
- Takes a one-cycle `start` strobe with a SIDE×SIDE handwriting bitmap, snapshots the bitmap, and scans it serially one pooled cell per clock.
- Produces an OUT×OUT down-sampled bitmap, a total ink count and an empty flag, then pulses `done`; the predictor consumes the reduced feature map.

Parameters:
- SIDE, 52, edge length of the input track bitmap in pixels; must be a multiple of POOL.
- POOL, 4, pooling window edge in pixels; OUT = SIDE/POOL (default 13).
- THRESH, 1, minimum count of set pixels in a POOL×POOL window for the pooled cell to be 1; legal range 1..POOL*POOL.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset, sampled on the clk rising edge
- start  input  1  one-cycle strobe: track is valid this cycle
- track  input  SIDE*SIDE  bitmap; pixel (x,y) = track[y*SIDE+x]
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse: results updated
- pooled  output  OUT*OUT  pooled bitmap; cell (c,r) = pooled[r*OUT+c]
- ink_count  output  12  total set pixels in the snapshot, 0..2704
- empty  output  1  ink_count == 0
- bbox  output  4*6  {max_y,max_x,min_y,min_x}, pixel coordinates; valid only with the optional feature

Behaviour:
- One clock, clk. All state resets synchronously when rst=0.
- Reset values: busy=0, done=0, pooled=0, ink_count=0, empty=1, bbox=0, FSM=IDLE, cell index=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On a clk edge with start=1, capture track into an internal snapshot register, clear the working accumulators, set index=0, go to SCAN.
  - busy rises on that same edge.
- SCAN:
  - Each cycle evaluates cell index k (r=k/OUT, c=k%OUT) from the snapshot.
  - n = popcount of pixels x∈[c*POOL, c*POOL+POOL-1], y∈[r*POOL, r*POOL+POOL-1].
  - Working bit k = (n >= THRESH). Working ink += n, width 12, no overflow possible.
  - k increments by 1. When k = OUT*OUT-1 has been evaluated, go to DONE.
- DONE (one cycle):
  - Copy the working bitmap to `pooled` and the working ink to `ink_count`.
  - empty = (ink == 0). done=1 for exactly this cycle. busy=0 from the next edge. Return to IDLE.
- Latency:
  - start sampled at edge E0; SCAN occupies edges E1..E169.
  - done is high in the cycle following edge E170.
  - New results are visible on the outputs in that same done-high cycle.
- Output registers hold their values from one done until the next done. A scan in progress does not disturb them.
- start while busy=1 (SCAN or DONE) is ignored, not queued. The snapshot is not modified mid-scan.
- start in the same cycle done is high is ignored; the earliest accepted restart is the cycle after done.
- Changes on `track` after capture have no effect on the current scan.
- Empty bitmap: scan still runs full length; done pulses with pooled=0, ink_count=0, empty=1.
- Reset mid-scan:
  - Scan aborts and all outputs return to reset values, including previously held results.
  - No done pulse is produced.
- Pooling is a pure window count against THRESH. There is no centering or scaling.

Optional Feature:
- Macro: TRACK_POOLER_BBOX_EN.
- Defined:
  - During SCAN, track the min/max x and y of every set pixel in the current window. Pixel coordinates come from the window origin plus offset.
  - Latch into `bbox` at DONE.
  - For an empty bitmap, bbox = 0.
- Undefined:
  - No bbox logic is synthesized; bbox is tied to 0 permanently.
  - All other behaviour and latency are identical.

Test Plan:
- All-zero track, start pulse → done exactly 170 cycles after the start edge; pooled=0, ink_count=0, empty=1, busy high for 170 cycles.
- Single pixel (0,0) set, THRESH=1 → pooled=bit 0 only, ink_count=1, empty=0. Single pixel (51,51) → pooled bit 168 only. With BBOX_EN, bbox min=max=(51,51).
- Pixels (4..7, 8..11) fully set (16 pixels) plus one pixel at (20,20), THRESH=2 → pooled bit (r=2,c=1)=bit 27 set, bit 70 clear, ink_count=17.
- All-ones track → pooled all 169 bits set, ink_count=2704. With BBOX_EN, bbox=(0,0)-(51,51).
- Second start 50 cycles into a scan with a different track → ignored; only one done pulse; results match the first snapshot. Changing track mid-scan also has no effect.
- rst=0 at cycle 100 of a scan following an earlier completed scan → no done; pooled/ink_count/bbox return to 0, empty=1, busy=0. A subsequent start completes normally.
